operand_fetch: RTL

Decode/operand-fetch stage that sits directly upstream of the 32x32 register file. It accepts one RV32I instruction at a time over a valid/ready handshake and drives the register file's two read addresses. It captures the register file's synchronous read data one cycle later and patches that data with a bypass from the writeback port. It then presents decoded operands, the immediate and the destination index to the execute stage over a second valid/ready handshake.

---
 rtl/operand_fetch_pkg.sv | 39 +++
 rtl/operand_fetch_imm_gen.sv | 36 +++
 rtl/operand_fetch.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the decode/operand-fetch stage and its immediate generator.
//   - RV32I opcode constants used for immediate and destination decode
//   - FSM state encoding of operand_fetch
//   - immediate format classification plus a helper mapping opcode -> format
package operand_fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_W   = 7;

  localparam logic [OPC_W-1:0] OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP     = 7'b0110011;

  typedef enum logic [1:0] {IDLE, READ, CAPT, VALID} state_t;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_t;

  // Immediate format of an opcode; R-type and unknown opcodes carry no immediate.
  function automatic imm_type_t imm_type_of(input logic [OPC_W-1:0] opcode);
    imm_type_t t;
    case (opcode)
      OP_IMM, LOAD, JALR: t = IMM_I;
      STORE:              t = IMM_S;
      BRANCH:             t = IMM_B;
      LUI, AUIPC:         t = IMM_U;
      JAL:                t = IMM_J;
      OP:                 t = IMM_NONE;
      default:            t = IMM_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/operand_fetch_imm_gen.sv
// Combinational RV32I immediate generator.
// Ports:
//   i_instr  in   32    instruction word
//   o_imm    out  XLEN  sign-extended immediate (0 for formats without one)
module imm_gen
  import operand_fetch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INSTR_W-1:0] i_instr,
  output logic [XLEN-1:0]    o_imm
);

  imm_type_t w_type;
  // funct3 never contributes to an immediate
  logic      w_unused_funct3;

  assign w_type          = imm_type_of(i_instr[6:0]);
  assign w_unused_funct3 = ^i_instr[14:12];

  // Signed sources are cast up to XLEN so the sign bit replicates.
  always_comb begin
    o_imm = '0;
    case (w_type)
      IMM_I: o_imm = XLEN'($signed(i_instr[31:20]));
      IMM_S: o_imm = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
      IMM_B: o_imm = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                                    i_instr[11:8], 1'b0}));
      IMM_U: o_imm = XLEN'($signed({i_instr[31:12], 12'b0}));
      IMM_J: o_imm = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                                    i_instr[30:21], 1'b0}));
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage in front of a 32x32 synchronous-read register file.
// Accepts one instruction, drives the register file read addresses, captures the
// read data a cycle later with writeback bypass, and holds a decoded bundle for
// execute while snooping writebacks so held operands stay current.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_valid/in_ready/in_instr/in_pc upstream instruction handshake
//   rf_rr1, rf_rr2                   registered register file read addresses
//   rf_rd1, rf_rd2                   register file read data (one cycle later)
//   wb_wren/wb_wr/wb_wd              writeback port (also writes the register file)
//   out_valid/out_ready              downstream bundle handshake
//   out_pc/out_instr/out_rs1_val/out_rs2_val/out_imm/out_rd  operand bundle
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [XLEN-1:0]    in_pc,
  output logic [RA_W-1:0]    rf_rr1,
  output logic [RA_W-1:0]    rf_rr2,
  input  logic [XLEN-1:0]    rf_rd1,
  input  logic [XLEN-1:0]    rf_rd2,
  input  logic               wb_wren,
  input  logic [RA_W-1:0]    wb_wr,
  input  logic [XLEN-1:0]    wb_wd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [XLEN-1:0]    out_rs1_val,
  output logic [XLEN-1:0]    out_rs2_val,
  output logic [XLEN-1:0]    out_imm,
  output logic [RA_W-1:0]    out_rd
);

  state_t             r_state;
  state_t             w_next;
  logic [INSTR_W-1:0] r_instr;
  logic [XLEN-1:0]    r_pc;
  logic               r_pend1;
  logic               r_pend2;
  logic [XLEN-1:0]    r_pval1;
  logic [XLEN-1:0]    r_pval2;

  logic               w_accept;
  logic               w_read;
  logic               w_capt;
  logic               w_snoop;
  logic               w_hit1;
  logic               w_hit2;
  logic [XLEN-1:0]    w_byp1;
  logic [XLEN-1:0]    w_byp2;
  logic [XLEN-1:0]    w_imm;
  logic               w_no_rd;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_instr (r_instr),
    .o_imm   (w_imm)
  );

  // rf_rr* hold the source indices from accept until the next accept.
  assign w_hit1 = wb_wren && (wb_wr == rf_rr1);
  assign w_hit2 = wb_wren && (wb_wr == rf_rr2);

  // x0 beats everything, then a same-cycle write, then the write seen during READ.
  assign w_byp1 = (rf_rr1 == '0) ? '0 : w_hit1 ? wb_wd : r_pend1 ? r_pval1 : rf_rd1;
  assign w_byp2 = (rf_rr2 == '0) ? '0 : w_hit2 ? wb_wd : r_pend2 ? r_pval2 : rf_rd2;

  assign w_no_rd   = (imm_type_of(r_instr[6:0]) == IMM_S) ||
                     (imm_type_of(r_instr[6:0]) == IMM_B);
  assign out_valid = (r_state == VALID);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state and per-state strobes
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    w_accept = 1'b0;
    w_read   = 1'b0;
    w_capt   = 1'b0;
    w_snoop  = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = READ;
        end
      end
      READ: begin
        w_read = 1'b1;
        w_next = CAPT;
      end
      CAPT: begin
        w_capt = 1'b1;
        w_next = VALID;
      end
      VALID: begin
        in_ready = out_ready;
        w_snoop  = 1'b1;
        if (out_ready) begin
          if (in_valid) begin
            w_accept = 1'b1;
            w_next   = READ;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr     <= '0;
      r_pc        <= '0;
      rf_rr1      <= '0;
      rf_rr2      <= '0;
      r_pend1     <= 1'b0;
      r_pend2     <= 1'b0;
      r_pval1     <= '0;
      r_pval2     <= '0;
      out_pc      <= '0;
      out_instr   <= '0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
      out_imm     <= '0;
      out_rd      <= '0;
    end else begin
      if (w_accept) begin
        r_instr <= in_instr;
        r_pc    <= in_pc;
        rf_rr1  <= RA_W'(in_instr[19:15]);
        rf_rr2  <= RA_W'(in_instr[24:20]);
      end
      // The register file returns the pre-write value for a write on its sampling edge.
      if (w_read) begin
        r_pend1 <= w_hit1;
        r_pend2 <= w_hit2;
        r_pval1 <= wb_wd;
        r_pval2 <= wb_wd;
      end
      if (w_capt) begin
        out_rs1_val <= w_byp1;
        out_rs2_val <= w_byp2;
        out_imm     <= w_imm;
        out_rd      <= w_no_rd ? '0 : RA_W'(r_instr[11:7]);
        out_pc      <= r_pc;
        out_instr   <= r_instr;
      end else if (w_snoop) begin
        if (w_hit1 && (rf_rr1 != '0)) out_rs1_val <= wb_wd;
        if (w_hit2 && (rf_rr2 != '0)) out_rs2_val <= wb_wd;
      end
    end
  end

endmodule
